// File: rtl/ppc_pkg.sv
// Shared widths and the fetch-queue entry type for the PPC front end.
package ppc_pkg;

    localparam int PC_W    = 64;
    localparam int INST_W  = 32;
    localparam int DWORD_W = 64;
    localparam int MADDR_W = 61;

    typedef struct packed {
        logic [0:INST_W-1] inst;
        logic [0:PC_W-1]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/ppc_fetch_fifo.sv
// Circular buffer of fetch entries: up to two pushes and one pop per cycle, with flush.
module ppc_fetch_fifo
    import ppc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push0_i,
    input  fetch_entry_t     push0_data_i,
    input  logic             push1_i,
    input  fetch_entry_t     push1_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push1_ok;
    fetch_entry_t     mem_q [DEPTH];

    assign pop_ok   = pop_i && (count_q != '0);
    assign push1_ok = push0_i && push1_i;
    assign tail_p1  = tail_q + PTR_W'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push1_ok) begin
                tail_d = tail_q + PTR_W'(2);
            end else if (push0_i) begin
                tail_d = tail_p1;
            end
            count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (!flush_i && push0_i) begin
            mem_q[tail_q] <= push0_data_i;
        end
        if (!flush_i && push1_ok) begin
            mem_q[tail_p1] <= push1_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/ppc_fetch_queue.sv
// Fetch stage: owns the fetch PC, splits doublewords into instructions and
// queues them for the execute core; redirects flush the queue and restart fetch.
module ppc_fetch_queue
    import ppc_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [0:PC_W-1] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [0:MADDR_W-1]   mem_addr,
    input  logic [0:DWORD_W-1]   mem_data,
    output logic                 mem_req,
    output logic                 inst_valid,
    output logic [0:INST_W-1]    inst,
    output logic [0:PC_W-1]      inst_pc,
    input  logic                 inst_ready,
    input  logic                 redirect_valid,
    input  logic [0:PC_W-1]      redirect_pc,
    output logic                 misaligned
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [0:PC_W-1]  fpc_q, fpc_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] slots;
    logic [CNT_W-1:0] free_slots;
    logic             two_slot;
    logic             fire;
    logic             pop;
    fetch_entry_t     ent0, ent1, head;

    // An fpc in the lower word of a doubleword yields two instructions, otherwise one.
    assign two_slot   = ~fpc_q[61];
    assign slots      = two_slot ? CNT_W'(2) : CNT_W'(1);
    assign free_slots = CNT_W'(DEPTH) - count;
    assign fire       = ~reset & ~redirect_valid & (free_slots >= slots);

    assign mem_req    = fire;
    assign mem_addr   = fpc_q[0:MADDR_W-1];

    assign ent0.inst  = two_slot ? mem_data[0:INST_W-1] : mem_data[INST_W:DWORD_W-1];
    assign ent0.pc    = fpc_q;
    assign ent1.inst  = mem_data[INST_W:DWORD_W-1];
    assign ent1.pc    = fpc_q + 64'd4;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign misaligned = mis_q;

    ppc_fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .flush_i      (redirect_valid),
        .push0_i      (fire),
        .push0_data_i (ent0),
        .push1_i      (fire & two_slot),
        .push1_data_i (ent1),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    always_comb begin
        fpc_d = fpc_q;
        mis_d = mis_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[0:PC_W-3], 2'b00};
            if (redirect_pc[PC_W-2:PC_W-1] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else if (fire) begin
            fpc_d = fpc_q + (two_slot ? 64'd8 : 64'd4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            fpc_q <= fpc_d;
            mis_q <= mis_d;
        end
    end

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Directed bench for ppc_fetch_queue with a combinational memory model.
module tb_ppc_fetch_queue;

    logic         clk;
    logic         reset;
    logic [0:60]  mem_addr;
    logic [0:63]  mem_data;
    logic         mem_req;
    logic         inst_valid;
    logic [0:31]  inst;
    logic [0:63]  inst_pc;
    logic         inst_ready;
    logic         redirect_valid;
    logic [0:63]  redirect_pc;
    logic         misaligned;

    int total;
    int bad;

    ppc_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_req        (mem_req),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word at byte address p holds A000_0000 + p, except doubleword 0.
    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        if (pc == 64'h0)      return 32'h3860_0041;
        else if (pc == 64'h4) return 32'h3860_0042;
        else                  return 32'hA000_0000 + pc[31:0];
    endfunction

    function automatic logic [63:0] dword_at(input logic [60:0] a);
        logic [63:0] base;
        base = {a, 3'b000};
        return {exp_inst(base), exp_inst(base + 64'd4)};
    endfunction

    assign mem_data = dword_at(mem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves time inside cycle 0 after reset release.
    task automatic release_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        chk("rst_valid",    inst_valid, 0);
        chk("rst_mis",      misaligned, 0);
        chk("rst_req",      mem_req,    0);
        chk("rst_addr",     mem_addr,   0);

        // basic fetch and 1-cycle latency
        inst_ready = 1'b1;
        release_reset();
        chk("t1_c0_req",    mem_req,  1);
        chk("t1_c0_addr",   mem_addr, 0);
        step();
        chk("t1_c1_valid",  inst_valid, 1);
        chk("t1_c1_inst",   inst,     32'h3860_0041);
        chk("t1_c1_pc",     inst_pc,  0);
        chk("t1_c1_req",    mem_req,  1);
        chk("t1_c1_addr",   mem_addr, 1);
        step();
        chk("t1_c2_inst",   inst,     32'h3860_0042);
        chk("t1_c2_pc",     inst_pc,  4);
        chk("t1_c2_req",    mem_req,  0);
        step();
        chk("t1_c3_pc",     inst_pc,  8);
        chk("t1_c3_inst",   inst,     32'hA000_0008);
        chk("t1_c3_req",    mem_req,  1);
        chk("t1_c3_addr",   mem_addr, 2);

        // fill with core stalled, then drain in order
        inst_ready = 1'b0;
        release_reset();
        chk("t2_c0_req",    mem_req, 1);
        step();
        chk("t2_c1_req",    mem_req, 1);
        chk("t2_c1_pc",     inst_pc, 0);
        step();
        chk("t2_c2_req",    mem_req, 0);
        chk("t2_c2_pc",     inst_pc, 0);
        step();
        chk("t2_c3_req",    mem_req, 0);
        chk("t2_c3_pc",     inst_pc, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_pc",   inst_pc, 64'(i * 4));
            chk("t2_drain_inst", inst,    exp_inst(64'(i * 4)));
            step();
        end

        // redirect into the upper word of a doubleword
        redirect_valid = 1'b1;
        redirect_pc    = 64'h104;
        #1;
        chk("t3_redir_req", mem_req, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t3_n1_valid",  inst_valid, 0);
        chk("t3_n1_addr",   mem_addr,   61'h20);
        chk("t3_n1_req",    mem_req,    1);
        step();
        chk("t3_n2_valid",  inst_valid, 1);
        chk("t3_n2_pc",     inst_pc,    64'h104);
        chk("t3_n2_inst",   inst,       32'hA000_0104);
        chk("t3_n2_addr",   mem_addr,   61'h21);
        chk("t3_n2_req",    mem_req,    1);
        step();
        chk("t3_n3_pc",     inst_pc,    64'h108);
        step();
        chk("t3_n4_pc",     inst_pc,    64'h10C);

        // redirect on a full queue with a pop in the same cycle
        inst_ready = 1'b0;
        release_reset();
        step();
        step();
        step();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        #1;
        chk("t4_full_req",  mem_req, 0);
        chk("t4_full_pc",   inst_pc, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t4_n1_valid",  inst_valid, 0);
        chk("t4_n1_addr",   mem_addr,   61'h60);
        chk("t4_n1_req",    mem_req,    1);
        step();
        chk("t4_n2_valid",  inst_valid, 1);
        chk("t4_n2_pc",     inst_pc,    64'h300);
        chk("t4_n2_inst",   inst,       32'hA000_0300);

        // misaligned redirect is sticky
        redirect_valid = 1'b1;
        redirect_pc    = 64'h202;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_mis",       misaligned, 1);
        chk("t5_addr",      mem_addr,   61'h40);
        chk("t5_valid",     inst_valid, 0);
        step();
        chk("t5_pc",        inst_pc,    64'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("t5_mis_hold",  misaligned, 1);
        chk("t5_addr2",     mem_addr,   61'h80);
        step();
        chk("t5_pc2",       inst_pc,    64'h400);

        // asynchronous reset with entries queued
        release_reset();
        chk("t6_mis_clr",   misaligned, 0);
        step();
        step();
        chk("t6_c2_valid",  inst_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", inst_valid, 0);
        chk("t6_async_req",   mem_req,    0);
        release_reset();
        chk("t6_re_addr",   mem_addr, 0);
        chk("t6_re_req",    mem_req,  1);
        step();
        chk("t6_re_pc",     inst_pc,  0);
        chk("t6_re_inst",   inst,     32'h3860_0041);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppc_fetch_queue.md
# ppc_fetch_queue

Instruction fetch stage directly upstream of the PPC execute core. It owns the fetch PC and reads 64-bit doublewords through memory read port 0. It splits each doubleword into one or two 32-bit instructions and buffers them, with their PCs, in a small queue. The core consumes them through a valid/ready handshake and redirects fetch on taken branches.

## Interface

Parameters:
- DEPTH, 4, queue entries (instruction + PC); power of two, ≥ 2
- RESET_PC, 64'h0, fetch PC loaded at reset

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- mem_addr  out  [0:60]  doubleword address to memory read port 0 (= fpc[0:60])
- mem_data  in  [0:63]  doubleword returned combinationally in the same cycle
- mem_req  out  1  high in cycles where mem_data is captured into the queue
- inst_valid  out  1  queue head holds a valid instruction
- inst  out  [0:31]  head instruction
- inst_pc  out  [0:63]  PC of head instruction
- inst_ready  in  1  core accepts head this cycle
- redirect_valid  in  1  flush queue and restart fetch
- redirect_pc  in  [0:63]  new fetch PC
- misaligned  out  1  sticky: a redirect arrived with redirect_pc[62:63] ≠ 0

## Operation

- State:
  - fpc[0:63], word-aligned.
  - Queue storage, head/tail pointers and count. The count is clog2(DEPTH+1) bits wide.
  - misaligned flag.
- Fetch slots: n = 2 if fpc[61] = 0, else 1.
  - n = 2: push mem_data[0:31] @fpc, then mem_data[32:63] @fpc+4.
  - n = 1: push only mem_data[32:63] @fpc.
- Fetch fires (mem_req = 1) when no redirect is present and (DEPTH − count) ≥ n. Free space uses the count at the start of the cycle; a pop in the same cycle does not create room.
- On fire, fpc ← fpc + 4·n, which always realigns fpc to the next doubleword. PC arithmetic is modulo 2^64.
- Pop: occurs when inst_valid & inst_ready. inst_valid = (count ≠ 0). inst and inst_pc are read directly from the head entry, with no extra register stage.
- Redirect (redirect_valid = 1):
  - A pop in the same cycle still counts as a transfer.
  - Then all entries are discarded: count ← 0 and pointers reset. No fetch is pushed that cycle.
  - fpc ← {redirect_pc[0:61], 2'b00}.
  - If redirect_pc[62:63] ≠ 0, misaligned ← 1. It stays set until reset.
- A redirect in the same cycle as a fetch that would fire: the redirect wins, and the fetch data is dropped.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH. inst_ready while empty has no effect.
- Reset values:
  - fpc = RESET_PC; count = 0; pointers = 0.
  - inst_valid = 0, misaligned = 0, mem_req = 0.
  - mem_addr = RESET_PC[0:60].
- Reset mid-operation: all entries are discarded immediately (asynchronous). Fetch restarts at RESET_PC on the first clock after deassertion.

## Timing

- mem_addr and mem_req are combinational from state and redirect_valid. mem_data is sampled at the posedge ending the fetch cycle.
- Fetch-to-use latency is 1 cycle: data fetched in cycle N is visible at the head (inst_valid = 1) in cycle N+1.
- Redirect in cycle N:
  - inst_valid = 0 in N+1, while fetching at the new PC.
  - First new instruction is valid in N+2.
- Steady state with inst_ready held high and fpc doubleword-aligned:
  - Fetch fires every cycle while count ≤ DEPTH−2.
  - Throughput reaches 1 instruction/cycle after fill.
- Output changes only at posedge, or asynchronously on reset assertion.

## Structure

- Shared package ppc_pkg holds:
  - PC_W = 64, INST_W = 32, DWORD_W = 64, MADDR_W = 61
  - a fetch-entry struct {inst, pc}
- Sub-module ppc_fetch_fifo: dual-push / single-pop circular buffer of fetch entries, with a flush input and count output.
- Top level holds fpc, fetch-slot logic, redirect handling and the misaligned flag.

## Test plan

- Reset with RESET_PC=0; memory dword0 = 38600041_38600042, inst_ready=1 → cycle 1: inst_valid=1, inst=38600041, inst_pc=0; cycle 2: inst=38600042, inst_pc=4.
- inst_ready=0 from reset, DEPTH=4 → mem_req fires in cycles 0 and 1, then stays 0; count=4, inst_pc stays 0, no entries lost or overwritten.
- redirect_pc=0x104 (upper half) → next fetch has mem_addr=0x20 and pushes a single entry with inst_pc=0x104; following fetch at fpc=0x108 pushes 2 entries.
- Redirect asserted with the queue full and inst_ready=1 in the same cycle → head counts as transferred; next cycle inst_valid=0; N+2 inst_pc=redirect_pc.
- redirect_pc=0x202 → fpc=0x200, misaligned=1, and it stays 1 across later redirects until reset.
- Assert reset while count=3 → inst_valid falls without waiting for a clock edge; after deassertion, fetch restarts at RESET_PC.
